// File: rtl/cpu_input_port_pkg.sv
// Shared types for the CPU input port: debounce FSM encoding and hex-to-7-segment
// constants, in the same segment order as the CPU LED path ({g,f,e,d,c,b,a}, active-high).
package cpu_input_port_pkg;

    typedef enum logic [1:0] {
        DB_IDLE_LO = 2'd0,
        DB_CHK_HI  = 2'd1,
        DB_IDLE_HI = 2'd2,
        DB_CHK_LO  = 2'd3
    } db_state_t;

    localparam logic [6:0] SEG_0 = 7'h3F;
    localparam logic [6:0] SEG_1 = 7'h06;
    localparam logic [6:0] SEG_2 = 7'h5B;
    localparam logic [6:0] SEG_3 = 7'h4F;
    localparam logic [6:0] SEG_4 = 7'h66;
    localparam logic [6:0] SEG_5 = 7'h6D;
    localparam logic [6:0] SEG_6 = 7'h7D;
    localparam logic [6:0] SEG_7 = 7'h07;
    localparam logic [6:0] SEG_8 = 7'h7F;
    localparam logic [6:0] SEG_9 = 7'h6F;
    localparam logic [6:0] SEG_A = 7'h77;
    localparam logic [6:0] SEG_B = 7'h7C;
    localparam logic [6:0] SEG_C = 7'h39;
    localparam logic [6:0] SEG_D = 7'h5E;
    localparam logic [6:0] SEG_E = 7'h79;
    localparam logic [6:0] SEG_F = 7'h71;

    function automatic logic [6:0] seg_encode(input logic [3:0] nib);
        case (nib)
            4'h0:    return SEG_0;
            4'h1:    return SEG_1;
            4'h2:    return SEG_2;
            4'h3:    return SEG_3;
            4'h4:    return SEG_4;
            4'h5:    return SEG_5;
            4'h6:    return SEG_6;
            4'h7:    return SEG_7;
            4'h8:    return SEG_8;
            4'h9:    return SEG_9;
            4'hA:    return SEG_A;
            4'hB:    return SEG_B;
            4'hC:    return SEG_C;
            4'hD:    return SEG_D;
            4'hE:    return SEG_E;
            default: return SEG_F;
        endcase
    endfunction

endpackage

// File: rtl/cpu_input_port_if.sv
// CPU-side read handshake of the input port (IN instruction strobe and returned data).
interface cpu_input_port_if #(
    parameter int DATA_W = 8
);
    logic              rd_en;
    logic [DATA_W-1:0] data_out;
    logic              data_ready;
    logic              overrun;

    modport master (output rd_en, input data_out, data_ready, overrun);
    modport slave  (input rd_en, output data_out, data_ready, overrun);
endinterface

// File: rtl/cpu_input_port_debouncer.sv
// Synchronizes the switch bank and enter button, debounces the button and emits a
// one-cycle registered press pulse on each accepted rising level.
//   state      | meaning
//   DB_IDLE_LO | stable low, waiting for a high
//   DB_CHK_HI  | counting consecutive high cycles
//   DB_IDLE_HI | stable high, waiting for a low
//   DB_CHK_LO  | counting consecutive low cycles
module cpu_input_port_debouncer
    import cpu_input_port_pkg::*;
#(
    parameter int DATA_W          = 8,
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 16
) (
    input  logic              clkin,
    input  logic              rst,
    input  logic [DATA_W-1:0] sw_in,
    input  logic              btn_in,
    output logic [DATA_W-1:0] sw_s,
    output logic              btn_stable,
    output logic              press
);
    localparam int CNT_W = $clog2(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [SYNC_STAGES-1:0]             btn_sync;
    logic [SYNC_STAGES-1:0][DATA_W-1:0] sw_sync;
    logic                               btn_s;
    db_state_t                          state, state_nxt;
    logic [CNT_W-1:0]                   cnt, cnt_nxt;
    logic                               press_nxt;

    always_ff @(posedge clkin) begin
        if (rst) begin
            btn_sync <= '0;
            sw_sync  <= '0;
        end else begin
            btn_sync <= {btn_sync[SYNC_STAGES-2:0], btn_in};
            sw_sync  <= {sw_sync[SYNC_STAGES-2:0], sw_in};
        end
    end

    assign btn_s = btn_sync[SYNC_STAGES-1];
    assign sw_s  = sw_sync[SYNC_STAGES-1];

    always_ff @(posedge clkin) begin
        if (rst) begin
            state <= DB_IDLE_LO;
            cnt   <= '0;
            press <= 1'b0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
            press <= press_nxt;
        end
    end

    // The counter saturates into a state change, so it never wraps.
    always_comb begin
        state_nxt = state;
        cnt_nxt   = '0;
        press_nxt = 1'b0;
        case (state)
            DB_IDLE_LO: begin
                if (btn_s) begin
                    state_nxt = DB_CHK_HI;
                    cnt_nxt   = CNT_W'(1);
                end
            end
            DB_CHK_HI: begin
                if (!btn_s) begin
                    state_nxt = DB_IDLE_LO;
                end else if (cnt == CNT_LAST) begin
                    state_nxt = DB_IDLE_HI;
                    press_nxt = 1'b1;
                end else begin
                    cnt_nxt = cnt + 1'b1;
                end
            end
            DB_IDLE_HI: begin
                if (!btn_s) begin
                    state_nxt = DB_CHK_LO;
                    cnt_nxt   = CNT_W'(1);
                end
            end
            DB_CHK_LO: begin
                if (btn_s) begin
                    state_nxt = DB_IDLE_HI;
                end else if (cnt == CNT_LAST) begin
                    state_nxt = DB_IDLE_LO;
                end else begin
                    cnt_nxt = cnt + 1'b1;
                end
            end
            default: state_nxt = DB_IDLE_LO;
        endcase
    end

    assign btn_stable = (state == DB_IDLE_HI) || (state == DB_CHK_LO);

endmodule

// File: rtl/cpu_input_port.sv
// CPU input port: latches the switch bank on each debounced enter press and holds it for
// the IN instruction. Optional INPUT_ECHO_EN adds registered 7-segment echo of the held value.
module cpu_input_port
    import cpu_input_port_pkg::*;
#(
    parameter int DATA_W          = 8,
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 16
) (
    input  logic              clkin,
    input  logic              rst,
    input  logic [DATA_W-1:0] sw_in,
    input  logic              btn_in,
    cpu_input_port_if.slave   bus
`ifdef INPUT_ECHO_EN
    ,
    output logic [6:0]        seg_hi,
    output logic [6:0]        seg_lo
`endif
);
    logic [DATA_W-1:0] sw_s;
    logic [DATA_W-1:0] hold;
    logic [DATA_W-1:0] data_out_q;
    logic              btn_stable;
    logic              press;
    logic              capture;
    logic              ready_q;
    logic              overrun_q;

    cpu_input_port_debouncer #(
        .DATA_W          (DATA_W),
        .SYNC_STAGES     (SYNC_STAGES),
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
    ) u_debouncer (
        .clkin      (clkin),
        .rst        (rst),
        .sw_in      (sw_in),
        .btn_in     (btn_in),
        .sw_s       (sw_s),
        .btn_stable (btn_stable),
        .press      (press)
    );

    // A press pulse always coincides with the debounced level being high.
    assign capture = press & btn_stable;

    always_ff @(posedge clkin) begin
        if (rst) begin
            hold       <= '0;
            data_out_q <= '0;
            ready_q    <= 1'b0;
            overrun_q  <= 1'b0;
        end else begin
            if (capture) hold <= sw_s;
            if (bus.rd_en) data_out_q <= hold;

            if (capture)        ready_q <= 1'b1;
            else if (bus.rd_en) ready_q <= 1'b0;

            if (bus.rd_en)               overrun_q <= 1'b0;
            else if (capture && ready_q) overrun_q <= 1'b1;
        end
    end

    assign bus.data_out   = data_out_q;
    assign bus.data_ready = ready_q;
    assign bus.overrun    = overrun_q;

`ifdef INPUT_ECHO_EN
    always_ff @(posedge clkin) begin
        if (rst) begin
            seg_hi <= '0;
            seg_lo <= '0;
        end else begin
            seg_hi <= seg_encode(hold[7:4]);
            seg_lo <= seg_encode(hold[3:0]);
        end
    end
`endif

endmodule

// File: tb/tb_cpu_input_port.sv
// Directed bench for cpu_input_port: reset, clean press latency, bounce, overrun,
// read/press collision, reset mid-debounce, and 7-segment echo when INPUT_ECHO_EN is set.
module tb_cpu_input_port;
    localparam int DATA_W = 8;

`ifdef INPUT_ECHO_EN
    localparam logic [6:0] EXP_SEG_3 = 7'h4F;
    localparam logic [6:0] EXP_SEG_4 = 7'h66;
    localparam logic [6:0] EXP_SEG_C = 7'h39;
    logic [6:0] seg_hi;
    logic [6:0] seg_lo;
`endif

    logic              clkin = 1'b0;
    logic              rst;
    logic [DATA_W-1:0] sw_in;
    logic              btn_in;
    int                checks = 0;
    int                errors = 0;

    cpu_input_port_if #(.DATA_W(DATA_W)) bus ();

    cpu_input_port #(
        .DATA_W          (DATA_W),
        .SYNC_STAGES     (2),
        .DEBOUNCE_CYCLES (16)
    ) dut (
        .clkin  (clkin),
        .rst    (rst),
        .sw_in  (sw_in),
        .btn_in (btn_in),
        .bus    (bus)
`ifdef INPUT_ECHO_EN
        ,
        .seg_hi (seg_hi),
        .seg_lo (seg_lo)
`endif
    );

    always #10 clkin = ~clkin;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clkin);
        #1;
    endtask

    task automatic ticks(input int n);
        repeat (n) tick();
    endtask

    task automatic wait_ready(output int n);
        n = 0;
        while (bus.data_ready !== 1'b1 && n < 40) begin
            tick();
            n++;
        end
    endtask

    task automatic read_port();
        bus.rd_en = 1'b1;
        tick();
        bus.rd_en = 1'b0;
    endtask

    task automatic do_press(input logic [DATA_W-1:0] sw);
        sw_in  = sw;
        btn_in = 1'b1;
        ticks(20);
        btn_in = 1'b0;
        ticks(20);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        int caps;

        rst       = 1'b1;
        btn_in    = 1'b1;
        sw_in     = 8'hFF;
        bus.rd_en = 1'b0;
        ticks(2);
        check("rst_data_out", 32'(bus.data_out), 32'h00);
        check("rst_ready", 32'(bus.data_ready), 32'h0);
        check("rst_overrun", 32'(bus.overrun), 32'h0);
`ifdef INPUT_ECHO_EN
        check("rst_seg_hi", 32'(seg_hi), 32'h00);
        check("rst_seg_lo", 32'(seg_lo), 32'h00);
`endif

        // Button held through reset: the press counts from release.
        rst = 1'b0;
        wait_ready(n);
        check("rst_release_lat", 32'(n), 32'd19);
        read_port();
        check("rst_release_data", 32'(bus.data_out), 32'hFF);
        btn_in = 1'b0;
        ticks(25);
        check("release_no_capture", 32'(bus.data_ready), 32'h0);

        // Clean press.
        sw_in  = 8'hA5;
        btn_in = 1'b1;
        wait_ready(n);
        check("clean_lat", 32'(n), 32'd19);
        check("clean_dout_before_read", 32'(bus.data_out), 32'hFF);
        read_port();
        check("clean_data", 32'(bus.data_out), 32'hA5);
        check("clean_ready_clr", 32'(bus.data_ready), 32'h0);
        ticks(20);
        btn_in = 1'b0;
        ticks(25);

        // Bounce on press and on release.
        sw_in = 8'h5A;
        caps  = 0;
        for (int k = 0; k < 10; k++) begin
            btn_in = (k % 2 == 0);
            for (int j = 0; j < 3; j++) begin
                tick();
                if (bus.data_ready === 1'b1) caps++;
            end
        end
        check("bounce_no_early", 32'(caps), 32'd0);
        btn_in = 1'b1;
        wait_ready(n);
        check("bounce_lat", 32'(n), 32'd19);
        ticks(20);
        for (int k = 0; k < 10; k++) begin
            btn_in = (k % 2 == 1);
            ticks(3);
        end
        btn_in = 1'b0;
        ticks(25);
        check("bounce_single_ovr", 32'(bus.overrun), 32'h0);
        check("bounce_ready", 32'(bus.data_ready), 32'h1);
        read_port();
        check("bounce_data", 32'(bus.data_out), 32'h5A);

        // Overrun.
        do_press(8'h11);
        check("ovr_first_ready", 32'(bus.data_ready), 32'h1);
        check("ovr_first_flag", 32'(bus.overrun), 32'h0);
        check("ovr_dout_held", 32'(bus.data_out), 32'h5A);
        do_press(8'h22);
        check("ovr_flag", 32'(bus.overrun), 32'h1);
        check("ovr_ready", 32'(bus.data_ready), 32'h1);
        read_port();
        check("ovr_data", 32'(bus.data_out), 32'h22);
        check("ovr_flag_clr", 32'(bus.overrun), 32'h0);
        check("ovr_ready_clr", 32'(bus.data_ready), 32'h0);

        // Read on the exact capture edge.
        do_press(8'h33);
        sw_in  = 8'h44;
        btn_in = 1'b1;
        ticks(18);
        bus.rd_en = 1'b1;
        tick();
        bus.rd_en = 1'b0;
        check("coll_data_old", 32'(bus.data_out), 32'h33);
        check("coll_ready", 32'(bus.data_ready), 32'h1);
        check("coll_overrun", 32'(bus.overrun), 32'h0);
        btn_in = 1'b0;
        ticks(20);
        read_port();
        check("coll_data_new", 32'(bus.data_out), 32'h44);
        check("coll_ready_clr", 32'(bus.data_ready), 32'h0);

        // Capture 3C; segments follow one cycle after ready.
        sw_in  = 8'h3C;
        btn_in = 1'b1;
        wait_ready(n);
        check("echo_lat", 32'(n), 32'd19);
`ifdef INPUT_ECHO_EN
        check("echo_seg_hi_old", 32'(seg_hi), 32'(EXP_SEG_4));
        check("echo_seg_lo_old", 32'(seg_lo), 32'(EXP_SEG_4));
        tick();
        check("echo_seg_hi", 32'(seg_hi), 32'(EXP_SEG_3));
        check("echo_seg_lo", 32'(seg_lo), 32'(EXP_SEG_C));
`endif
        btn_in = 1'b0;
        ticks(20);

        // Reset in the middle of a debounce discards it.
        sw_in  = 8'h77;
        btn_in = 1'b1;
        ticks(10);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("midrst_data_out", 32'(bus.data_out), 32'h00);
        check("midrst_ready", 32'(bus.data_ready), 32'h0);
        check("midrst_overrun", 32'(bus.overrun), 32'h0);
`ifdef INPUT_ECHO_EN
        check("midrst_seg_hi", 32'(seg_hi), 32'h00);
        check("midrst_seg_lo", 32'(seg_lo), 32'h00);
`endif
        ticks(8);
        btn_in = 1'b0;
        ticks(25);
        check("midrst_no_capture", 32'(bus.data_ready), 32'h0);
        read_port();
        check("midrst_hold_clr", 32'(bus.data_out), 32'h00);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
